// File: rtl/clk_meter.sv
// Measures period and high time of a slow input in clk cycles.
// Optional 4-capture averaging is enabled by defining CLK_METER_AVG4_EN.
//
// Ports:
//   clk, rst  - system clock, asynchronous active-high reset
//   en        - measurement enable
//   sig_in    - waveform under test, asynchronous to clk
//   period_o  - last measured period in clk cycles
//   high_o    - last measured high time in clk cycles
//   valid_o   - one-cycle pulse: period_o/high_o just updated
//   stuck_o   - level: no rising edge within TIMEOUT cycles
module clk_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             stuck_o
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    STUCK
  } state_t;

  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  state_t           state;
  logic             s1;
  logic             s;
  logic             s_d;
  logic             rise;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;

  assign rise = s & ~s_d;

`ifdef CLK_METER_AVG4_EN
  logic [CNT_W+1:0] acc_p;
  logic [CNT_W+1:0] acc_h;
  logic [1:0]       n_cap;
  logic [CNT_W+1:0] sum_p;
  logic [CNT_W+1:0] sum_h;

  assign sum_p = acc_p + {2'b00, per_cnt};
  assign sum_h = acc_h + {2'b00, hi_cnt};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      s1       <= 1'b0;
      s        <= 1'b0;
      s_d      <= 1'b0;
      per_cnt  <= '0;
      hi_cnt   <= '0;
      period_o <= '0;
      high_o   <= '0;
      valid_o  <= 1'b0;
      stuck_o  <= 1'b0;
`ifdef CLK_METER_AVG4_EN
      acc_p    <= '0;
      acc_h    <= '0;
      n_cap    <= '0;
`endif
    end else begin
      s1      <= sig_in;
      s       <= s1;
      s_d     <= s;
      valid_o <= 1'b0;
      if (!en) begin
        // results and stuck flag hold while disabled
        state   <= IDLE;
        per_cnt <= '0;
        hi_cnt  <= '0;
`ifdef CLK_METER_AVG4_EN
        acc_p   <= '0;
        acc_h   <= '0;
        n_cap   <= '0;
`endif
      end else begin
        unique case (state)
          IDLE: begin
            if (rise) begin
              state   <= MEASURE;
              per_cnt <= CNT_W'(1);
              hi_cnt  <= CNT_W'(1);
            end
          end
          MEASURE: begin
            if (rise) begin
              // rise beats timeout in the same cycle
              per_cnt <= CNT_W'(1);
              hi_cnt  <= CNT_W'(1);
`ifdef CLK_METER_AVG4_EN
              if (n_cap == 2'd3) begin
                period_o <= CNT_W'(sum_p >> 2);
                high_o   <= CNT_W'(sum_h >> 2);
                valid_o  <= 1'b1;
                acc_p    <= '0;
                acc_h    <= '0;
                n_cap    <= '0;
              end else begin
                acc_p <= sum_p;
                acc_h <= sum_h;
                n_cap <= n_cap + 2'd1;
              end
`else
              period_o <= per_cnt;
              high_o   <= hi_cnt;
              valid_o  <= 1'b1;
`endif
            end else if (per_cnt == TO) begin
              state   <= STUCK;
              stuck_o <= 1'b1;
`ifdef CLK_METER_AVG4_EN
              acc_p   <= '0;
              acc_h   <= '0;
              n_cap   <= '0;
`endif
            end else begin
              per_cnt <= per_cnt + CNT_W'(1);
              hi_cnt  <= hi_cnt + {{(CNT_W-1){1'b0}}, s};
            end
          end
          STUCK: begin
            if (rise) begin
              state   <= MEASURE;
              stuck_o <= 1'b0;
              per_cnt <= CNT_W'(1);
              hi_cnt  <= CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_meter.sv
// Directed self-checking bench for clk_meter (TIMEOUT=100).
// Expectations follow CLK_METER_AVG4_EN when it is defined.
module tb_clk_meter;

`ifdef CLK_METER_AVG4_EN
  localparam int NCAP = 4;
`else
  localparam int NCAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        sig_in;
  logic [15:0] period_o;
  logic [15:0] high_o;
  logic        valid_o;
  logic        stuck_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int g_cyc = 0;
  int vc = 0;
  int vcyc = 0;
  int last_gap = 0;
  int dbl = 0;
  logic prev_v = 1'b0;
  int lgp[8];
  int lgh[8];

  clk_meter #(.CNT_W(16), .TIMEOUT(100)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .sig_in(sig_in),
    .period_o(period_o),
    .high_o(high_o),
    .valid_o(valid_o),
    .stuck_o(stuck_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid_o) begin
      vc++;
      last_gap = cyc - vcyc;
      vcyc = cyc;
      lgp[vc % 8] = int'(period_o);
      lgh[vc % 8] = int'(high_o);
    end
    if (valid_o && prev_v) dbl++;
    prev_v = valid_o;
  end

  task automatic gen(input int p, input int h, input int n);
    for (int k = 0; k < n; k++) begin
      sig_in = 1'b1;
      g_cyc = cyc;
      repeat (h) @(negedge clk);
      sig_in = 1'b0;
      repeat (p - h) @(negedge clk);
    end
    #1;
  endtask

  task automatic wait_stuck(output int n);
    n = 0;
    while (!stuck_o && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    en = 1'b0;
    sig_in = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (period_o !== 16'd0) begin
      fails++;
      $display("FAIL reset_period: got %0d want 0", period_o);
    end
    tests++;
    if (high_o !== 16'd0) begin
      fails++;
      $display("FAIL reset_high: got %0d want 0", high_o);
    end
    tests++;
    if (valid_o !== 1'b0 || stuck_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: got v=%b s=%b want 0 0",
               valid_o, stuck_o);
    end
    rst = 1'b0;
    @(negedge clk);
    en = 1'b1;
  endtask

  task automatic test_basic;
    int v0;
    v0 = vc;
    gen(10, 3, 1 + 2 * NCAP);
    tests++;
    if (vc - v0 != 2) begin
      fails++;
      $display("FAIL basic_count: got %0d want 2", vc - v0);
    end
    tests++;
    if (period_o !== 16'd10 || high_o !== 16'd3) begin
      fails++;
      $display("FAIL basic_vals: got %0d/%0d want 10/3",
               period_o, high_o);
    end
    tests++;
    if (last_gap != 10 * NCAP) begin
      fails++;
      $display("FAIL basic_gap: got %0d want %0d",
               last_gap, 10 * NCAP);
    end
    tests++;
    if (stuck_o !== 1'b0) begin
      fails++;
      $display("FAIL basic_stuck: got %b want 0", stuck_o);
    end
  endtask

  task automatic test_stuck_low;
    int v0;
    int n;
    v0 = vc;
    wait_stuck(n);
    tests++;
    if (stuck_o !== 1'b1) begin
      fails++;
      $display("FAIL stuck_low_set: got %b want 1", stuck_o);
    end
    tests++;
    if (cyc - g_cyc != 103) begin
      fails++;
      $display("FAIL stuck_low_time: got %0d want 103",
               cyc - g_cyc);
    end
    tests++;
    if (vc != v0) begin
      fails++;
      $display("FAIL stuck_low_novalid: got %0d want 0", vc - v0);
    end
    gen(10, 3, 1);
    tests++;
    if (stuck_o !== 1'b0 || vc != v0) begin
      fails++;
      $display("FAIL stuck_resume1: got s=%b dv=%0d want 0 0",
               stuck_o, vc - v0);
    end
    gen(10, 3, NCAP);
    tests++;
    if (vc != v0 + 1 || period_o !== 16'd10 || high_o !== 16'd3) begin
      fails++;
      $display("FAIL stuck_resume2: got dv=%0d %0d/%0d want 1 10/3",
               vc - v0, period_o, high_o);
    end
  endtask

  task automatic test_stuck_high;
    int n;
    sig_in = 1'b1;
    wait_stuck(n);
    tests++;
    if (stuck_o !== 1'b1) begin
      fails++;
      $display("FAIL stuck_high_set: got %b want 1", stuck_o);
    end
    tests++;
    if (period_o !== 16'd10 || high_o !== 16'd3) begin
      fails++;
      $display("FAIL stuck_high_hold: got %0d/%0d want 10/3",
               period_o, high_o);
    end
    sig_in = 1'b0;
  endtask

  task automatic test_enable;
    int v0;
    gen(10, 3, 2);
    sig_in = 1'b1;
    repeat (3) @(negedge clk);
    sig_in = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    v0 = vc;
    en = 1'b0;
    repeat (5) @(negedge clk);
    en = 1'b1;
    gen(7, 2, 1);
    tests++;
    if (vc != v0) begin
      fails++;
      $display("FAIL en_novalid: got %0d want 0", vc - v0);
    end
    gen(7, 2, NCAP);
    tests++;
    if (vc != v0 + 1 || period_o !== 16'd7 || high_o !== 16'd2) begin
      fails++;
      $display("FAIL en_resume: got dv=%0d %0d/%0d want 1 7/2",
               vc - v0, period_o, high_o);
    end
  endtask

  task automatic test_async_reset;
    int v0;
    sig_in = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (period_o !== 16'd0 || high_o !== 16'd0 ||
        valid_o !== 1'b0 || stuck_o !== 1'b0) begin
      fails++;
      $display("FAIL async_rst: got %0d/%0d v=%b s=%b want 0/0 0 0",
               period_o, high_o, valid_o, stuck_o);
    end
    sig_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    v0 = vc;
    gen(10, 3, 1 + NCAP);
    tests++;
    if (vc != v0 + 1 || period_o !== 16'd10 || high_o !== 16'd3) begin
      fails++;
      $display("FAIL rst_recover: got dv=%0d %0d/%0d want 1 10/3",
               vc - v0, period_o, high_o);
    end
  endtask

  task automatic test_mixed;
    int v0;
    en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    v0 = vc;
    gen(8, 4, 2);
    gen(12, 6, 2);
    gen(4, 2, 1);
`ifdef CLK_METER_AVG4_EN
    tests++;
    if (vc != v0 + 1 || period_o !== 16'd10 || high_o !== 16'd5) begin
      fails++;
      $display("FAIL avg4: got dv=%0d %0d/%0d want 1 10/5",
               vc - v0, period_o, high_o);
    end
`else
    tests++;
    if (vc != v0 + 4) begin
      fails++;
      $display("FAIL mixed_count: got %0d want 4", vc - v0);
    end
    tests++;
    if (lgp[(v0 + 1) % 8] != 8 || lgh[(v0 + 1) % 8] != 4 ||
        lgp[(v0 + 2) % 8] != 8 || lgh[(v0 + 2) % 8] != 4) begin
      fails++;
      $display("FAIL mixed_8: got %0d/%0d %0d/%0d want 8/4 8/4",
               lgp[(v0 + 1) % 8], lgh[(v0 + 1) % 8],
               lgp[(v0 + 2) % 8], lgh[(v0 + 2) % 8]);
    end
    tests++;
    if (lgp[(v0 + 3) % 8] != 12 || lgh[(v0 + 3) % 8] != 6 ||
        lgp[(v0 + 4) % 8] != 12 || lgh[(v0 + 4) % 8] != 6) begin
      fails++;
      $display("FAIL mixed_12: got %0d/%0d %0d/%0d want 12/6 12/6",
               lgp[(v0 + 3) % 8], lgh[(v0 + 3) % 8],
               lgp[(v0 + 4) % 8], lgh[(v0 + 4) % 8]);
    end
`endif
    tests++;
    if (dbl != 0) begin
      fails++;
      $display("FAIL valid_width: got %0d long pulses want 0", dbl);
    end
  endtask

  initial begin
    foreach (lgp[i]) begin
      lgp[i] = 0;
      lgh[i] = 0;
    end
    test_reset();
    test_basic();
    test_stuck_low();
    test_stuck_high();
    test_enable();
    test_async_reset();
    test_mixed();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
